// File: rtl/unicorn_pkg.sv
// Shared definitions for the Unicorn Explosion map pipeline: tile codes,
// map geometry, scroller state encoding and the fixed demo pattern.
package unicorn_pkg;

    localparam int MAP_TILES = 8;
    localparam int TILE_W    = 2;

    localparam logic [TILE_W-1:0] TILE_EMPTY = 2'd0;
    localparam logic [TILE_W-1:0] TILE_LOW   = 2'd1;
    localparam logic [TILE_W-1:0] TILE_HIGH  = 2'd2;
    localparam logic [TILE_W-1:0] TILE_RSVD  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } state_e;

    // Demo sequence 0,0,1,0,0,2,0,0 indexed by step number modulo 8.
    function automatic logic [TILE_W-1:0] fixed_tile(input logic [2:0] idx);
        case (idx)
            3'd2:    fixed_tile = TILE_LOW;
            3'd5:    fixed_tile = TILE_HIGH;
            default: fixed_tile = TILE_EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11); advances only when en is high.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = {q_q[14:0], q_q[15] ^ q_q[13] ^ q_q[12] ^ q_q[10]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/map_scroller.sv
// Scrolling obstacle map and game-step strobe for Unicorn Explosion.
// Build option MAP_FIXED_PATTERN_EN replaces random tiles with a fixed demo cycle.
module map_scroller
    import unicorn_pkg::*;
#(
    parameter int unsigned BASE_PERIOD     = 25000000,
    parameter int unsigned PERIOD_STEP     = 1000000,
    parameter int unsigned MIN_PERIOD      = 5000000,
    parameter int unsigned TILES_PER_LEVEL = 32,
    parameter int unsigned GAP_MIN         = 2,
    parameter logic [15:0] SEED            = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        is_dead,
    output logic [15:0] map_tiles,
    output logic        step,
    output logic [3:0]  level,
    output logic [1:0]  state
);

    localparam int          MAP_W  = MAP_TILES * TILE_W;
    localparam logic [31:0] BASE_P = 32'(BASE_PERIOD);
    localparam logic [31:0] STEP_P = 32'(PERIOD_STEP);
    localparam logic [31:0] MIN_P  = 32'(MIN_PERIOD);
    localparam logic [15:0] TPL    = 16'(TILES_PER_LEVEL);

    state_e             state_q, state_d;
    logic [MAP_W-1:0]   map_q, map_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [15:0]        scnt_q, scnt_d;
    logic [3:0]         level_q, level_d;
    logic               step_q, step_d;

    logic [31:0]        reduction;
    logic [31:0]        period;
    logic [TILE_W-1:0]  new_tile;
    logic               do_step;
    logic               clear;

    // Reduction is computed in 32 bits so a large level never wraps the period.
    always_comb begin
        reduction = 32'(level_q) * STEP_P;
        period    = MIN_P;
        if (reduction < BASE_P && (BASE_P - reduction) >= MIN_P) begin
            period = BASE_P - reduction;
        end
    end

`ifdef MAP_FIXED_PATTERN_EN
    logic [2:0] idx_q, idx_d;

    always_comb begin
        new_tile = fixed_tile(idx_q);
        idx_d    = idx_q;
        if (clear) begin
            idx_d = 3'd0;
        end else if (do_step) begin
            idx_d = idx_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= 3'd0;
        end else begin
            idx_q <= idx_d;
        end
    end
`else
    logic [15:0] lfsr_q;
    logic [7:0]  gap_q, gap_d;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (do_step),
        .q   (lfsr_q)
    );

    // After any obstacle, force at least GAP_MIN empty tiles.
    always_comb begin
        new_tile = TILE_EMPTY;
        gap_d    = gap_q;
        if (gap_q != 8'd0) begin
            new_tile = TILE_EMPTY;
        end else begin
            case (lfsr_q[2:0])
                3'd5, 3'd6: new_tile = TILE_LOW;
                3'd7:       new_tile = TILE_HIGH;
                default:    new_tile = TILE_EMPTY;
            endcase
        end
        if (clear) begin
            gap_d = 8'd0;
        end else if (do_step) begin
            if (gap_q != 8'd0) begin
                gap_d = gap_q - 8'd1;
            end else if (new_tile != TILE_EMPTY) begin
                gap_d = 8'(GAP_MIN);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_q <= 8'd0;
        end else begin
            gap_q <= gap_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        map_d   = map_q;
        cnt_d   = cnt_q;
        scnt_d  = scnt_q;
        level_d = level_q;
        step_d  = 1'b0;
        do_step = 1'b0;
        clear   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                clear = 1'b1;
                if (run) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!run) begin
                    state_d = ST_IDLE;
                    clear   = 1'b1;
                end else if (is_dead) begin
                    // Death wins over a coinciding step: no shift this cycle.
                    state_d = ST_FROZEN;
                end else if (cnt_q == period - 32'd1) begin
                    do_step = 1'b1;
                    step_d  = 1'b1;
                    cnt_d   = 32'd0;
                    map_d   = {map_q[MAP_W-TILE_W-1:0], new_tile};
                    if (scnt_q + 16'd1 >= TPL) begin
                        scnt_d = 16'd0;
                        if (level_q != 4'd15) begin
                            level_d = level_q + 4'd1;
                        end
                    end else begin
                        scnt_d = scnt_q + 16'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_FROZEN: begin
                if (!run) begin
                    state_d = ST_IDLE;
                    clear   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                clear   = 1'b1;
            end
        endcase

        if (clear) begin
            map_d   = '0;
            cnt_d   = 32'd0;
            scnt_d  = 16'd0;
            level_d = 4'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            map_q   <= '0;
            cnt_q   <= 32'd0;
            scnt_q  <= 16'd0;
            level_q <= 4'd0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            map_q   <= map_d;
            cnt_q   <= cnt_d;
            scnt_q  <= scnt_d;
            level_q <= level_d;
            step_q  <= step_d;
        end
    end

    assign map_tiles = map_q;
    assign step      = step_q;
    assign level     = level_q;
    assign state     = state_q;

endmodule

// File: tb/tb_map_scroller.sv
// Directed bench for map_scroller using small periods and a reference tile model.
module tb_map_scroller;

    localparam int          BASE = 10;
    localparam int          PSTEP = 2;
    localparam int          PMIN = 4;
    localparam int          TPL = 4;
    localparam int          GAPM = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        is_dead = 1'b0;
    logic [15:0] map_tiles;
    logic        step;
    logic [3:0]  level;
    logic [1:0]  state;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] m_lfsr;
    logic [15:0] m_map;
    int          m_gap;
    int          m_idx;
    int          m_lvl;
    int          m_sc;
    int          m_since;

    map_scroller #(
        .BASE_PERIOD    (BASE),
        .PERIOD_STEP    (PSTEP),
        .MIN_PERIOD     (PMIN),
        .TILES_PER_LEVEL(TPL),
        .GAP_MIN        (GAPM),
        .SEED           (SEED)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .is_dead  (is_dead),
        .map_tiles(map_tiles),
        .step     (step),
        .level    (level),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_period(input int lvl);
        int p;
        p = BASE - lvl * PSTEP;
        if (p < PMIN) p = PMIN;
        return p;
    endfunction

    task automatic model_enter();
        m_map   = 16'h0;
        m_gap   = 0;
        m_idx   = 0;
        m_lvl   = 0;
        m_sc    = 0;
        m_since = 99;
    endtask

    task automatic model_step();
        logic [1:0] t;
`ifdef MAP_FIXED_PATTERN_EN
        case (m_idx % 8)
            2:       t = 2'd1;
            5:       t = 2'd2;
            default: t = 2'd0;
        endcase
        m_idx++;
`else
        if (m_gap > 0) begin
            t = 2'd0;
            m_gap--;
        end else begin
            case (m_lfsr[2:0])
                3'd5, 3'd6: t = 2'd1;
                3'd7:       t = 2'd2;
                default:    t = 2'd0;
            endcase
            if (t != 2'd0) m_gap = GAPM;
        end
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
        m_map = {m_map[13:0], t};
        m_sc++;
        if (m_sc == TPL) begin
            m_sc = 0;
            if (m_lvl < 15) m_lvl++;
        end
    endtask

    task automatic wait_step(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!step && cyc < 200);
        if (!step) chk("step_timeout", 32'(step), 32'd1);
    endtask

    task automatic do_step(input string tag);
        int cyc;
        int p;
        p = exp_period(m_lvl);
        wait_step(cyc);
        chk({tag, "_period"}, cyc, p);
        model_step();
        chk({tag, "_map"}, map_tiles, m_map);
        chk({tag, "_level"}, level, m_lvl);
        chk({tag, "_state"}, state, 2'd1);
        chk({tag, "_no_rsvd"}, 32'(map_tiles[1:0] == 2'd3), 32'd0);
        if (map_tiles[1:0] != 2'd0) begin
            if (m_since != 99) chk({tag, "_gap"}, 32'(m_since >= GAPM), 32'd1);
            m_since = 0;
        end else if (m_since != 99) begin
            m_since++;
        end
    endtask

    initial begin
        m_lfsr = SEED;
        model_enter();
        repeat (2) @(negedge clk);
        chk("rst_map", map_tiles, 16'h0);
        chk("rst_step", step, 1'b0);
        chk("rst_level", level, 4'd0);
        chk("rst_state", state, 2'd0);
        rst = 1'b0;

        // is_dead ignored while idle
        is_dead = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_dead_state", state, 2'd0);
        chk("idle_dead_step", step, 1'b0);
        run = 1'b1;
        @(negedge clk);
        chk("idle_dead_enter", state, 2'd1);
        is_dead = 1'b0;
        model_enter();

        // periods 10,8,6,4,4... and level saturation after 60 steps
        for (int i = 0; i < 60; i++) do_step("ramp");
        chk("ramp_level_sat", level, 4'd15);
        do_step("ramp_post");
        do_step("ramp_post");

        // asynchronous reset mid-run
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_map", map_tiles, 16'h0);
        chk("arst_step", step, 1'b0);
        chk("arst_level", level, 4'd0);
        chk("arst_state", state, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        m_lfsr = SEED;
        model_enter();
        @(negedge clk);
        chk("arst_reenter", state, 2'd1);
        do_step("arst_first");

        // long random run
        for (int i = 0; i < 2000; i++) do_step("rand");

        // death coinciding with terminal count
        repeat (exp_period(m_lvl) - 1) @(negedge clk);
        is_dead = 1'b1;
        @(negedge clk);
        chk("dead_state", state, 2'd2);
        chk("dead_step", step, 1'b0);
        chk("dead_map", map_tiles, m_map);
        chk("dead_level", level, m_lvl);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("frozen_step", step, 1'b0);
        end
        chk("frozen_map", map_tiles, m_map);
        run = 1'b0;
        is_dead = 1'b0;
        @(negedge clk);
        chk("frozen_exit_state", state, 2'd0);
        chk("frozen_exit_map", map_tiles, 16'h0);
        chk("frozen_exit_level", level, 4'd0);

        // re-enter without reseeding, then leave directly from RUN
        run = 1'b1;
        @(negedge clk);
        chk("rerun_state", state, 2'd1);
        model_enter();
        for (int i = 0; i < 6; i++) do_step("rerun");
        run = 1'b0;
        @(negedge clk);
        chk("run_exit_state", state, 2'd0);
        chk("run_exit_map", map_tiles, 16'h0);
        chk("run_exit_level", level, 4'd0);
        chk("run_exit_step", step, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
